// File: rtl/hann_window_pkg.sv
// Shared helpers for the Hann window block: ROM sizing, mirror addressing,
// rounding constant and the elaboration-time coefficient generator.
package hann_window_pkg;

  localparam longint PI_Q30 = 64'sd3373259426;

  function automatic int rom_depth(input int frame_len);
    return frame_len / 2 + 1;
  endfunction

  function automatic int rom_aw(input int frame_len);
    return (frame_len / 2 + 1 > 1) ? $clog2(frame_len / 2 + 1) : 1;
  endfunction

  function automatic int mirror_addr(input int idx, input int frame_len);
    return (idx <= frame_len / 2) ? idx : frame_len - idx;
  endfunction

  function automatic longint round_const(input int coef_bw);
    return longint'(1) << (coef_bw - 1);
  endfunction

  // 0.5 - 0.5*cos(2*pi*k/N) == sin^2(pi*k/N); Taylor series in Q30 keeps it integer-only.
  function automatic longint hann_coef(input int k, input int frame_len, input int coef_bw);
    longint x;
    longint x2;
    longint term;
    longint s;
    longint val;
    longint lim;
    x    = (PI_Q30 * longint'(k)) / longint'(frame_len);
    x2   = (x * x) >>> 30;
    term = x;
    s    = x;
    for (int n = 1; n <= 12; n++) begin
      term = -(((term * x2) >>> 30) / longint'((2 * n) * (2 * n + 1)));
      s    = s + term;
    end
    val = ((s * s) + (longint'(1) << (59 - coef_bw))) >>> (60 - coef_bw);
    lim = (longint'(1) << coef_bw) - 1;
    return (val > lim) ? lim : val;
  endfunction

endpackage

// File: rtl/hann_rom.sv
// Half-length Hann coefficient ROM with a registered read (one cycle latency).
// Contents are generated at elaboration for the given FRAME_LEN/COEF_BW.
module hann_rom import hann_window_pkg::*; #(
  parameter int FRAME_LEN = 256,
  parameter int COEF_BW   = 16,
  parameter int AW        = rom_aw(FRAME_LEN)
) (
  input  logic               clk_i,
  input  logic [AW-1:0]      addr_i,
  output logic [COEF_BW-1:0] coef_o
);

  localparam int DEPTH = rom_depth(FRAME_LEN);

  logic [COEF_BW-1:0] rom_tbl [2**AW];
  logic [COEF_BW-1:0] coef_d;
  logic [COEF_BW-1:0] coef_q;

  for (genvar k = 0; k < 2**AW; k++) begin : g_tbl
    if (k < DEPTH) begin : g_used
      assign rom_tbl[k] = COEF_BW'(hann_coef(k, FRAME_LEN, COEF_BW));
    end else begin : g_pad
      assign rom_tbl[k] = '0;
    end
  end

  always_comb begin
    coef_d = rom_tbl[addr_i];
  end

  always_ff @(posedge clk_i) begin
    coef_q <= coef_d;
  end

  assign coef_o = coef_q;

endmodule

// File: rtl/hann_window.sv
// Periodic Hann window between framing and FFT: captures each held element once,
// scales it by a mirrored ROM coefficient and rounds; 4-cycle latency, no stalls.
module hann_window import hann_window_pkg::*; #(
  parameter int D_BW        = 16,
  parameter int COEF_BW     = 16,
  parameter int O_BW        = 16,
  parameter int FRAME_LEN   = 256,
  parameter int CADENCE_CYC = 3
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic signed [D_BW-1:0] data_i,
  input  logic                   valid_i,
  input  logic                   last_i,
  output logic signed [O_BW-1:0] data_o,
  output logic                   valid_o,
  output logic                   last_o,
  output logic                   frame_err_o
);

  localparam int HW = (CADENCE_CYC > 1) ? $clog2(CADENCE_CYC) : 1;
  localparam int IW = $clog2(FRAME_LEN);
  localparam int AW = rom_aw(FRAME_LEN);
  localparam int PW = D_BW + COEF_BW + 1;
  localparam logic [HW-1:0]        HOLD_MAX = HW'(CADENCE_CYC - 1);
  localparam logic [IW-1:0]        IDX_MAX  = IW'(FRAME_LEN - 1);
  localparam logic signed [PW-1:0] RND      = PW'(round_const(COEF_BW));

  logic [HW-1:0] hold_d, hold_q;
  logic [IW-1:0] idx_d, idx_q;
  logic          err_d, err_q;
  logic          cap;

  logic                   s0_v_d, s0_v_q, s0_last_d, s0_last_q;
  logic signed [D_BW-1:0] s0_dat_d, s0_dat_q;
  logic [AW-1:0]          s0_addr_d, s0_addr_q;
  logic [COEF_BW-1:0]     coef;

  logic                   s1_v_d, s1_v_q, s1_last_d, s1_last_q;
  logic signed [D_BW-1:0] s1_dat_d, s1_dat_q;

  logic                   s2_v_d, s2_v_q, s2_last_d, s2_last_q;
  logic signed [PW-1:0]   a_ext, c_ext, p_d, p_q, sum;

  logic signed [O_BW-1:0] data_d, data_q;
  logic                   valid_d, valid_q, last_d, last_q;

  // Element cadence tracking, frame index and length checking.
  always_comb begin
    hold_d = hold_q;
    idx_d  = idx_q;
    err_d  = err_q;
    cap    = valid_i && (hold_q == HOLD_MAX);
    if (!valid_i || hold_q == HOLD_MAX) begin
      hold_d = '0;
    end else begin
      hold_d = hold_q + HW'(1);
    end
    if (cap) begin
      if (last_i || idx_q == IDX_MAX) begin
        idx_d = '0;
        if (last_i != (idx_q == IDX_MAX)) begin
          err_d = 1'b1;
        end
      end else begin
        idx_d = idx_q + IW'(1);
      end
    end
  end

  hann_rom #(
    .FRAME_LEN (FRAME_LEN),
    .COEF_BW   (COEF_BW),
    .AW        (AW)
  ) u_rom (
    .clk_i  (clk_i),
    .addr_i (s0_addr_q),
    .coef_o (coef)
  );

  always_comb begin
    s0_v_d    = cap;
    s0_dat_d  = cap ? data_i : s0_dat_q;
    s0_last_d = cap ? last_i : s0_last_q;
    s0_addr_d = cap ? AW'(mirror_addr(int'(idx_q), FRAME_LEN)) : s0_addr_q;

    s1_v_d    = s0_v_q;
    s1_dat_d  = s0_dat_q;
    s1_last_d = s0_last_q;

    // Coefficient is unsigned, so it gets a zero sign bit before the signed multiply.
    a_ext     = PW'(s1_dat_q);
    c_ext     = PW'({1'b0, coef});
    s2_v_d    = s1_v_q;
    s2_last_d = s1_last_q;
    p_d       = a_ext * c_ext;

    sum       = p_q + RND;
    valid_d   = s2_v_q;
    last_d    = s2_v_q && s2_last_q;
    data_d    = s2_v_q ? O_BW'(sum >>> COEF_BW) : data_q;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      hold_q    <= '0;
      idx_q     <= '0;
      err_q     <= 1'b0;
      s0_v_q    <= 1'b0;
      s0_dat_q  <= '0;
      s0_last_q <= 1'b0;
      s0_addr_q <= '0;
      s1_v_q    <= 1'b0;
      s1_dat_q  <= '0;
      s1_last_q <= 1'b0;
      s2_v_q    <= 1'b0;
      s2_last_q <= 1'b0;
      p_q       <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      last_q    <= 1'b0;
    end else begin
      hold_q    <= hold_d;
      idx_q     <= idx_d;
      err_q     <= err_d;
      s0_v_q    <= s0_v_d;
      s0_dat_q  <= s0_dat_d;
      s0_last_q <= s0_last_d;
      s0_addr_q <= s0_addr_d;
      s1_v_q    <= s1_v_d;
      s1_dat_q  <= s1_dat_d;
      s1_last_q <= s1_last_d;
      s2_v_q    <= s2_v_d;
      s2_last_q <= s2_last_d;
      p_q       <= p_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      last_q    <= last_d;
    end
  end

  assign data_o      = data_q;
  assign valid_o     = valid_q;
  assign last_o      = last_q;
  assign frame_err_o = err_q;

endmodule

// File: tb/tb_hann_window.sv
// Randomized bench for hann_window against a queue-based reference of the windowing rules.
module tb_hann_window;

  localparam int D_BW = 16, COEF_BW = 16, O_BW = 16, FRAME_LEN = 8, CAD = 3, LAT = 4;

  logic                   clk     = 1'b0;
  logic                   rst_i   = 1'b1;
  logic signed [D_BW-1:0] data_i  = '0;
  logic                   valid_i = 1'b0;
  logic                   last_i  = 1'b0;
  logic signed [O_BW-1:0] data_o;
  logic                   valid_o, last_o, frame_err_o;

  hann_window #(
    .D_BW(D_BW), .COEF_BW(COEF_BW), .O_BW(O_BW),
    .FRAME_LEN(FRAME_LEN), .CADENCE_CYC(CAD)
  ) dut (
    .clk_i(clk), .rst_i(rst_i), .data_i(data_i), .valid_i(valid_i), .last_i(last_i),
    .data_o(data_o), .valid_o(valid_o), .last_o(last_o), .frame_err_o(frame_err_o)
  );

  always #5 clk = ~clk;

  typedef struct { longint val; bit last; int due; } exp_t;
  exp_t   exp_q[$];
  exp_t   ce;
  int     n_chk = 0, n_fail = 0, cyc = 0, m_idx = 0, err_from = -1;
  longint w [FRAME_LEN/2+1];

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic longint model_y(input longint d, input int idx);
    int k;
    k = (idx <= FRAME_LEN/2) ? idx : FRAME_LEN - idx;
    return (d * w[k] + 32768) >>> 16;
  endfunction

  function automatic int rnd_sample();
    return int'($urandom_range(0, 65535)) - 32768;
  endfunction

  // Reference: every capture yields one output LAT cycles later; length rules drive the sticky flag.
  task automatic model_capture(input int d, input bit last);
    exp_t e;
    e.val  = model_y(d, m_idx);
    e.last = last;
    e.due  = cyc + LAT;
    exp_q.push_back(e);
    if (last && m_idx != FRAME_LEN-1 && err_from < 0) err_from = cyc + 1;
    if (!last && m_idx == FRAME_LEN-1 && err_from < 0) err_from = cyc + 1;
    if (last || m_idx == FRAME_LEN-1) m_idx = 0;
    else m_idx = m_idx + 1;
  endtask

  task automatic drive_elem(input int d, input bit last);
    for (int h = 0; h < CAD; h++) begin
      @(posedge clk); #1;
      valid_i = 1'b1;
      data_i  = D_BW'(d);
      last_i  = (h == CAD-1) && last;
      if (h == CAD-1) model_capture(d, last);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      valid_i = 1'b0;
      last_i  = 1'b0;
      data_i  = D_BW'(rnd_sample());
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_i   = 1'b1;
    valid_i = 1'b0;
    last_i  = 1'b0;
    exp_q.delete();
    m_idx    = 0;
    err_from = -1;
    repeat (2) @(posedge clk);
    #1 rst_i = 1'b0;
  endtask

  task automatic frame_const(input int v);
    for (int e = 0; e < FRAME_LEN; e++) drive_elem(v, e == FRAME_LEN-1);
  endtask

  always @(negedge clk) begin
    if (rst_i) begin
      chk("rst_valid_o", valid_o, 0);
      chk("rst_data_o", data_o, 0);
      chk("rst_last_o", last_o, 0);
      chk("rst_frame_err_o", frame_err_o, 0);
    end else begin
      if (valid_o) begin
        chk("valid_o_expected", longint'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          ce = exp_q.pop_front();
          chk("data_o", data_o, ce.val);
          chk("last_o", last_o, longint'(ce.last));
          chk("valid_o_cycle", cyc, ce.due);
        end
      end else begin
        chk("idle_last_o", last_o, 0);
        if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
          chk("valid_o_at_due", valid_o, 1);
          void'(exp_q.pop_front());
        end
      end
      chk("frame_err_o", frame_err_o, longint'(err_from >= 0 && cyc >= err_from));
    end
  end

  initial begin
    longint rom_ref [FRAME_LEN/2+1];
    longint s1_ref  [FRAME_LEN];
    int     len;
    real    x;
    rom_ref = '{0, 9598, 32768, 55938, 65535};
    s1_ref  = '{0, 146, 500, 854, 1000, 854, 500, 146};

    for (int k = 0; k <= FRAME_LEN/2; k++) begin
      x    = 65536.0 * (0.5 - 0.5 * $cos(2.0 * 3.14159265358979 * k / FRAME_LEN));
      w[k] = longint'($floor(x + 0.5));
      if (w[k] > 65535) w[k] = 65535;
      chk("model_rom", w[k], rom_ref[k]);
    end
    for (int i = 0; i < FRAME_LEN; i++) begin
      chk("model_pos_1000", model_y(1000, i), s1_ref[i]);
      chk("model_neg_1000", model_y(-1000, i), -s1_ref[i]);
    end
    chk("model_min_idx4", model_y(-32768, 4), -32767);
    chk("model_max_idx4", model_y(32767, 4), 32767);

    repeat (3) @(posedge clk);
    #1 rst_i = 1'b0;

    frame_const(1000);
    frame_const(-1000);
    for (int e = 0; e < FRAME_LEN; e++) drive_elem(e == 4 ? -32768 : rnd_sample(), e == FRAME_LEN-1);
    for (int e = 0; e < FRAME_LEN; e++) drive_elem(e == 4 ? 32767 : rnd_sample(), e == FRAME_LEN-1);
    idle(6);

    for (int e = 0; e < 6; e++) drive_elem(1000, e == 5);
    frame_const(1000);
    idle(6);
    do_reset();

    for (int e = 0; e < 9; e++) drive_elem(500, 1'b0);
    idle(6);
    do_reset();

    for (int e = 0; e < 3; e++) drive_elem(1000, 1'b0);
    @(posedge clk); #1;
    valid_i = 1'b1;
    data_i  = D_BW'(1000);
    do_reset();
    frame_const(1000);
    idle(6);

    for (int f = 0; f < 20; f++) begin
      len = ($urandom_range(0, 4) == 0) ? int'($urandom_range(5, 10)) : FRAME_LEN;
      for (int e = 0; e < len; e++) begin
        if ($urandom_range(0, 9) == 0) idle(int'($urandom_range(1, 3)));
        drive_elem(rnd_sample(), e == len-1);
      end
      if (f == 9) do_reset();
    end
    idle(12);
    chk("drain_queue_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
